// File: rtl/calc_seq.sv
// Calculator operation sequencer: key tokens in, ALU operands out, result to display.
// Optional CALC_OVF_TRAP_EN: an overflowing result breaks the chain and clears A.
module calc_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [1:0] key_type,
    input  logic [7:0] key_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    output logic       disp_valid,
    input  logic       disp_ready,
    output logic [7:0] disp_value,
    output logic       disp_zero,
    output logic       disp_ovf,
    output logic       seq_err,
    output logic       busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] GOT_A  = 3'd1;
    localparam logic [2:0] GOT_OP = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] SHOW   = 3'd4;

    localparam logic [1:0] T_OPND  = 2'b00;
    localparam logic [1:0] T_OPER  = 2'b01;
    localparam logic [1:0] T_CLEAR = 2'b10;
    localparam logic [1:0] T_RSVD  = 2'b11;

    logic [2:0] state;
    logic       take;

    assign key_ready  = (state == IDLE) || (state == GOT_A) || (state == GOT_OP);
    assign busy       = (state == EXEC) || (state == SHOW);
    assign disp_valid = (state == SHOW);
    assign take       = key_valid & key_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            disp_value <= '0;
            disp_zero  <= 1'b0;
            disp_ovf   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            case (state)
                IDLE, GOT_A, GOT_OP: begin
                    if (take) begin
                        unique case (key_type)
                            T_OPND: begin
                                if (state == GOT_OP) begin
                                    alu_b <= key_data;
                                    state <= EXEC;
                                end else begin
                                    alu_a <= key_data;
                                    state <= GOT_A;
                                end
                            end
                            T_OPER: begin
                                // An operator with no operand A is out of sequence
                                if (state == IDLE) begin
                                    seq_err <= 1'b1;
                                end else begin
                                    alu_op <= key_data[1:0];
                                    state  <= GOT_OP;
                                end
                            end
                            T_CLEAR: begin
                                alu_a      <= '0;
                                alu_b      <= '0;
                                alu_op     <= '0;
                                disp_value <= '0;
                                disp_zero  <= 1'b0;
                                disp_ovf   <= 1'b0;
                                seq_err    <= 1'b0;
                                state      <= IDLE;
                            end
                            T_RSVD: begin
                            end
                        endcase
                    end
                end
                EXEC: begin
                    disp_value <= alu_result;
                    alu_a      <= alu_result;
                    disp_zero  <= alu_zero;
                    disp_ovf   <= alu_overflow & ~alu_op[1];
                    state      <= SHOW;
                end
                SHOW: begin
                    if (disp_ready) begin
`ifdef CALC_OVF_TRAP_EN
                        if (disp_ovf) begin
                            alu_a <= '0;
                            state <= IDLE;
                        end else begin
                            state <= GOT_A;
                        end
`else
                        state <= GOT_A;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq: directed plan cases plus randomized
// chains checked against an arithmetic reference of the calculator.
module tb_calc_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [1:0] key_type = 2'b00;
    logic [7:0] key_data = 8'h00;
    logic [7:0] alu_a, alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero, alu_overflow;
    logic       disp_valid;
    logic       disp_ready = 1'b0;
    logic [7:0] disp_value;
    logic       disp_zero, disp_ovf, seq_err, busy;

    int errors = 0;
    int checks = 0;

`ifdef CALC_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    calc_seq dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_ready(key_ready),
        .key_type(key_type), .key_data(key_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_value(disp_value), .disp_zero(disp_zero),
        .disp_ovf(disp_ovf), .seq_err(seq_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Combinational ALU; its overflow pin is deliberately 1 for logic ops
    always_comb begin
        logic [8:0] s;
        s = 9'd0;
        alu_overflow = 1'b0;
        alu_result = 8'h00;
        case (alu_op)
            2'b00: begin
                s = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = s[7:0];
                alu_overflow = s[8];
            end
            2'b01: begin
                alu_result = alu_a - alu_b;
                alu_overflow = (alu_a < alu_b);
            end
            2'b10: begin
                alu_result = alu_a & alu_b;
                alu_overflow = 1'b1;
            end
            default: begin
                alu_result = alu_a ^ alu_b;
                alu_overflow = 1'b1;
            end
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    // Reference model: accumulator value and whether a chain is open
    int m_a = 0;
    bit m_have = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_calc(input int a, input int op, input int b,
                            output int r, output int z, output int v);
        case (op)
            0: begin r = (a + b) % 256; v = (a + b > 255) ? 1 : 0; end
            1: begin r = (a - b + 256) % 256; v = (a < b) ? 1 : 0; end
            2: begin r = a & b; v = 0; end
            default: begin r = a ^ b; v = 0; end
        endcase
        z = (r == 0) ? 1 : 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic key(input logic [1:0] t, input logic [7:0] d);
        int n;
        n = 0;
        while (!key_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (!key_ready) begin
            errors++;
            checks++;
            $display("FAIL key_ready_timeout observed=0 expected=1");
        end
        key_valid = 1'b1;
        key_type = t;
        key_data = d;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic run_calc(input bit fresh, input logic [7:0] a,
                            input logic [1:0] op, input logic [7:0] b,
                            input int stall);
        int r, z, v;
        if (fresh || !m_have) begin
            key(2'b00, a);
            m_a = a;
        end
        key(2'b01, {6'd0, op});
        key(2'b00, b);
        ref_calc(m_a, op, b, r, z, v);
        chk("exec_busy", busy, 1);
        chk("exec_nodisp", disp_valid, 0);
        chk("exec_kready", key_ready, 0);
        @(posedge clk); #1;
        chk("show_valid", disp_valid, 1);
        chk("show_value", disp_value, r);
        chk("show_zero", disp_zero, z);
        chk("show_ovf", disp_ovf, v);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_value", disp_value, r);
            chk("stall_valid", disp_valid, 1);
            chk("stall_kready", key_ready, 0);
        end
        disp_ready = 1'b1;
        @(posedge clk); #1;
        disp_ready = 1'b0;
        if (TRAP && v == 1) begin
            m_a = 0;
            m_have = 1'b0;
        end else begin
            m_a = r;
            m_have = 1'b1;
        end
        chk("after_valid", disp_valid, 0);
        chk("after_kready", key_ready, 1);
        chk("after_acc", alu_a, m_a);
    endtask

    task automatic do_clear();
        key(2'b10, 8'h00);
        m_a = 0;
        m_have = 1'b0;
        chk("clr_err", seq_err, 0);
        chk("clr_a", alu_a, 0);
        chk("clr_disp", disp_value, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_a"}, alu_a, 0);
        chk({tag, "_b"}, alu_b, 0);
        chk({tag, "_op"}, alu_op, 0);
        chk({tag, "_dv"}, disp_valid, 0);
        chk({tag, "_val"}, disp_value, 0);
        chk({tag, "_z"}, disp_zero, 0);
        chk({tag, "_ovf"}, disp_ovf, 0);
        chk({tag, "_err"}, seq_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_kr"}, key_ready, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_calc(1'b1, 8'h64, 2'b00, 8'h32, 0);
        chk("plan_add", disp_value, 8'h96);

        run_calc(1'b1, 8'hC8, 2'b00, 8'h64, 0);
        chk("plan_wrap", disp_value, 8'h2C);
        chk("plan_wrap_ovf", disp_ovf, 1);
        if (TRAP) begin
            chk("trap_acc", alu_a, 0);
            key(2'b01, 8'h00);
            chk("trap_idle", seq_err, 1);
            do_clear();
        end else begin
            run_calc(1'b0, 8'h00, 2'b01, 8'h2C, 0);
            chk("plan_sub0", disp_value, 8'h00);
            chk("plan_sub0_z", disp_zero, 1);
        end
        do_clear();

        run_calc(1'b1, 8'hF0, 2'b10, 8'h3C, 0);
        chk("plan_and", disp_value, 8'h30);
        chk("plan_and_ovf", disp_ovf, 0);
        run_calc(1'b0, 8'h00, 2'b11, 8'hFF, 0);
        chk("plan_xor", disp_value, 8'hCF);
        do_clear();

        key(2'b01, 8'h02);
        chk("seq_err_set", seq_err, 1);
        chk("seq_err_op", alu_op, 0);
        chk("seq_err_busy", busy, 0);
        do_clear();

        run_calc(1'b1, 8'h12, 2'b00, 8'h34, 10);
        chk("stall_res", disp_value, 8'h46);

        key(2'b00, 8'h11);
        key(2'b01, 8'h00);
        key(2'b00, 8'h22);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("mid");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        m_a = 0;
        m_have = 1'b0;
        run_calc(1'b1, 8'h05, 2'b01, 8'h07, 0);
        chk("post_rst_sub", disp_value, 8'hFE);

        for (int i = 0; i < 40; i++) begin
            int sel;
            logic [7:0] a, b;
            logic [1:0] op;
            sel = $urandom_range(0, 9);
            a = 8'($urandom);
            b = 8'($urandom);
            op = 2'($urandom);
            if (sel == 0) do_clear();
            if (sel == 1) key(2'b11, 8'($urandom));
            if (sel == 2 && m_have) key(2'b01, 8'($urandom));
            run_calc(sel >= 7, a, op, b, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
